keccak_arbiter: RTL and testbench
=================================

# keccak_arbiter

Round-robin arbiter and sequencer that shares one `keccak` core among `NUM_REQ` Kyber requesters (matrix-A XOF, noise PRF, H/G hash, KDF). It grants one requester at a time and latches that requester's mode and lengths for the whole transaction. Between grant and the core's done pulse it steers the granted requester's input stream into the core and routes output beats back. It sits between the Kyber top-level control and the single `keccak` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `BW_DATA`, `` `BW_DATA `` (64): stream word width.
- `BW_IBLEN`, `` `BW_IBLEN ``: input byte length width.
- `BW_OBLEN`, `` `BW_OBLEN ``: output byte length width.

Ports (clock and reset first; requester fields are flattened, requester k occupies slice k):
- `i_clk`  in  1  single clock, rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_req`  in  NUM_REQ  transaction request, level; held until `o_req_done[k]`.
- `i_req_mode`  in  2*NUM_REQ  00 SHAKE128, 01 SHAKE256, 10 SHA3_256, 11 SHA3_512.
- `i_req_ibytes_len`  in  BW_IBLEN*NUM_REQ  input byte count.
- `i_req_obytes_len`  in  BW_OBLEN*NUM_REQ  output byte count (used by SHAKE only).
- `i_req_ibytes`  in  BW_DATA*NUM_REQ  input words.
- `i_req_ibytes_valid`  in  NUM_REQ  input word valid.
- `o_req_ibytes_ready`  out  NUM_REQ  equals `i_kc_ibytes_ready` for the granted requester; 0 for all others.
- `o_req_grant`  out  NUM_REQ  one-hot grant, registered.
- `o_req_obytes`  out  BW_DATA  shared output bus, equals `i_kc_obytes`.
- `o_req_obytes_valid`  out  NUM_REQ  output beat valid, granted requester only.
- `o_req_done`  out  NUM_REQ  one-cycle completion pulse, registered.
- `o_req_err`  out  NUM_REQ  one-cycle pulse, coincident with `o_req_done`, when the transaction was rejected.
- `o_kc_mode`  out  2  mode to the core (latched).
- `o_kc_ibytes_len`  out  BW_IBLEN  input length to the core (latched).
- `o_kc_obytes_len`  out  BW_OBLEN  output length to the core (latched).
- `o_kc_ibytes`  out  BW_DATA  input word to the core.
- `o_kc_ibytes_valid`  out  1  input valid to the core.
- `i_kc_ibytes_ready`, `i_kc_obytes`, `i_kc_obytes_valid`, `i_kc_obytes_done`  in  1 / BW_DATA / 1 / 1  core status and output.
- `o_busy`  out  1  high whenever the state is not S_IDLE.

## Operation
- FSM states:
  - S_IDLE: if `|i_req`, pick winner w with the round-robin arbiter starting at `ptr`. Latch `gidx<=w`, mode, and both lengths. Go to S_ERR if the latched ibytes_len is 0, else go to S_BUSY.
  - S_BUSY: steer the stream in both directions. Go to S_DONE when `i_kc_obytes_done` is high.
  - S_ERR: one cycle, then S_DONE. The core is never driven.
  - S_DONE: one cycle. Pulse `o_req_done[gidx]` (and `o_req_err[gidx]` if entered from S_ERR). Set `ptr<=gidx+1` modulo NUM_REQ. Go to S_IDLE.
- In S_BUSY the input side is combinational: `o_kc_ibytes = i_req_ibytes[gidx]`, `o_kc_ibytes_valid = i_req_ibytes_valid[gidx]`.
- In every other state `o_kc_ibytes_valid = 0`. The core's S_IDLE cannot then be started spuriously.
- `o_req_obytes_valid[k] = i_kc_obytes_valid & (state==S_BUSY) & (gidx==k)`.
- The latched mode and lengths hold from grant until the core reaches S_IDLE, independent of later requester input changes.
- Priority: the round-robin pointer searches upward from `ptr` with wrap-around. After reset, `ptr=0`, so requester 0 wins a tie.
- Requester drops `i_req` mid-transaction: ignored. The core cannot abort, so the transaction runs to `i_kc_obytes_done` and `o_req_done` still pulses.
- Requester keeps `i_req` high after done: it is re-arbitrated as the lowest priority, since `ptr` has advanced past it.
- `o_req_ibytes_valid` beats from non-granted requesters are ignored; their `o_req_ibytes_ready` is 0.

## Timing
- Reset values: state S_IDLE, `ptr=0`, `gidx=0`. All outputs are 0: grant, done, err, busy, `o_kc_*`, `o_req_*`.
- `i_req[k]` sampled high in S_IDLE at cycle t gives `o_req_grant[k]=1` and a stable `o_kc_mode`/lengths at t+1. The first forwarded input beat is possible at t+1.
- `i_kc_obytes_done` at cycle d gives `o_req_done` pulsed at d+1, with the grant still high. The grant drops at d+2.
- The next arbitration is sampled at d+2, so the earliest next grant is d+3. Turnaround is 2 dead cycles.
- Zero-length request sampled at t: grant at t+1 (S_ERR), grant at t+2 (S_DONE) with done=err=1, grant low at t+3.
- Asynchronous reset mid-transaction clears everything immediately. The core shares `i_rstn`, so both sides restart from idle.

## Structure
- Mode codes, `BW_DATA`, `BW_IBLEN`, `BW_OBLEN`, and the state encodings belong in the shared `config_keccak.v`.
- One sub-module: `rr_arbiter`, parameterised by N. It is combinational: inputs are the request vector and the pointer; outputs are the one-hot grant plus its index. It is reused later by other shared Kyber resources.

## Test plan
- Single requester: req0, SHA3_256, ibytes_len=32. Input beats pass through, and 4 output beats are delivered only on `o_req_obytes_valid[0]`. Done pulses at d+1 and the digest matches the golden model.
- Simultaneous req0..req3 after reset: grants go 0,1,2,3 in order, each start separated by ≥2 dead cycles from the previous done. Results are bit-exact per requester.
- req1 held high continuously while req2 pulses: the grant alternates 1,2,1 and neither requester starves.
- req2 with ibytes_len=0: grant 1 cycle later, then done=err=1 one cycle after that. `o_kc_ibytes_valid` stays 0 throughout.
- req0 SHAKE128 with obytes_len=504: mode and length stay latched while req0 changes its inputs mid-stream. 63 output beats are routed to req0.
- `i_rstn` asserted during S_BUSY: all outputs go to 0 asynchronously. After release, req3 is granted within 1 cycle.

Source files
------------

// File: rtl/keccak_arbiter_pkg.sv
// Shared constants for the Keccak-core arbiter: stream widths, Kyber mode codes
// and the sequencer state encoding.
package keccak_arbiter_pkg;

  localparam int unsigned KC_BW_DATA  = 64;
  localparam int unsigned KC_BW_IBLEN = 16;
  localparam int unsigned KC_BW_OBLEN = 16;

  localparam logic [1:0] MODE_SHAKE128 = 2'b00;
  localparam logic [1:0] MODE_SHAKE256 = 2'b01;
  localparam logic [1:0] MODE_SHA3_256 = 2'b10;
  localparam logic [1:0] MODE_SHA3_512 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2,
    S_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr with wrap-around,
// returning the one-hot winner and its index.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = i + 32'(ptr);
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NUM_REQ requesters: round-robin grant, latched
// mode/lengths per transaction, and stream steering until the core's done.
module keccak_arbiter
  import keccak_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BW_DATA  = KC_BW_DATA,
  parameter int unsigned BW_IBLEN = KC_BW_IBLEN,
  parameter int unsigned BW_OBLEN = KC_BW_OBLEN
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [2*NUM_REQ-1:0]         i_req_mode,
  input  logic [BW_IBLEN*NUM_REQ-1:0]  i_req_ibytes_len,
  input  logic [BW_OBLEN*NUM_REQ-1:0]  i_req_obytes_len,
  input  logic [BW_DATA*NUM_REQ-1:0]   i_req_ibytes,
  input  logic [NUM_REQ-1:0]           i_req_ibytes_valid,
  output logic [NUM_REQ-1:0]           o_req_ibytes_ready,
  output logic [NUM_REQ-1:0]           o_req_grant,
  output logic [BW_DATA-1:0]           o_req_obytes,
  output logic [NUM_REQ-1:0]           o_req_obytes_valid,
  output logic [NUM_REQ-1:0]           o_req_done,
  output logic [NUM_REQ-1:0]           o_req_err,
  output logic [1:0]                   o_kc_mode,
  output logic [BW_IBLEN-1:0]          o_kc_ibytes_len,
  output logic [BW_OBLEN-1:0]          o_kc_obytes_len,
  output logic [BW_DATA-1:0]           o_kc_ibytes,
  output logic                         o_kc_ibytes_valid,
  input  logic                         i_kc_ibytes_ready,
  input  logic [BW_DATA-1:0]           i_kc_obytes,
  input  logic                         i_kc_obytes_valid,
  input  logic                         i_kc_obytes_done,
  output logic                         o_busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gidx;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  done;
  logic [NUM_REQ-1:0]  err;
  logic [1:0]          kc_mode;
  logic [BW_IBLEN-1:0] kc_ilen;
  logic [BW_OBLEN-1:0] kc_olen;

  logic [NUM_REQ-1:0]  win_grant;
  logic [IW-1:0]       win_idx;
  logic                win_valid;
  logic [1:0]          win_mode;
  logic [BW_IBLEN-1:0] win_ilen;
  logic [BW_OBLEN-1:0] win_olen;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_mode = i_req_mode[2*32'(win_idx) +: 2];
  assign win_ilen = i_req_ibytes_len[BW_IBLEN*32'(win_idx) +: BW_IBLEN];
  assign win_olen = i_req_obytes_len[BW_OBLEN*32'(win_idx) +: BW_OBLEN];

  // done/err are one-cycle pulses that coincide with S_DONE
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= '0;
      kc_mode <= '0;
      kc_ilen <= '0;
      kc_olen <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            gidx    <= win_idx;
            grant   <= win_grant;
            kc_mode <= win_mode;
            kc_ilen <= win_ilen;
            kc_olen <= win_olen;
            state   <= (win_ilen == '0) ? S_ERR : S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_kc_obytes_done) begin
            done  <= grant;
            state <= S_DONE;
          end
        end
        S_ERR: begin
          done  <= grant;
          err   <= grant;
          state <= S_DONE;
        end
        S_DONE: begin
          grant <= '0;
          ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_kc_ibytes        = '0;
    o_kc_ibytes_valid  = 1'b0;
    o_req_ibytes_ready = '0;
    o_req_obytes_valid = '0;
    if (state == S_BUSY) begin
      o_kc_ibytes              = i_req_ibytes[BW_DATA*32'(gidx) +: BW_DATA];
      o_kc_ibytes_valid        = i_req_ibytes_valid[gidx];
      o_req_ibytes_ready[gidx] = i_kc_ibytes_ready;
      o_req_obytes_valid[gidx] = i_kc_obytes_valid;
    end
  end

  assign o_req_grant     = grant;
  assign o_req_done      = done;
  assign o_req_err       = err;
  assign o_req_obytes    = i_kc_obytes;
  assign o_kc_mode       = kc_mode;
  assign o_kc_ibytes_len = kc_ilen;
  assign o_kc_obytes_len = kc_olen;
  assign o_busy          = (state != S_IDLE);

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter; the bench itself plays the keccak core.
module tb_keccak_arbiter;
  import keccak_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned BD = 64;
  localparam int unsigned BI = 16;
  localparam int unsigned BO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] mode;
  logic [BI*NR-1:0] ilen;
  logic [BO*NR-1:0] olen;
  logic [BD*NR-1:0] ibytes;
  logic [NR-1:0]   ivalid;
  logic [NR-1:0]   req_ready, grant, ovalid, done, err;
  logic [BD-1:0]   obytes;
  logic [1:0]      kc_mode;
  logic [BI-1:0]   kc_ilen;
  logic [BO-1:0]   kc_olen;
  logic [BD-1:0]   kc_ibytes;
  logic            kc_ivalid;
  logic            kc_ready;
  logic [BD-1:0]   kc_obytes;
  logic            kc_ov, kc_done;
  logic            busy;

  int errors = 0;
  int checks = 0;

  keccak_arbiter #(
    .NUM_REQ  (NR),
    .BW_DATA  (BD),
    .BW_IBLEN (BI),
    .BW_OBLEN (BO)
  ) dut (
    .i_clk              (clk),
    .i_rstn             (rst_n),
    .i_req              (req),
    .i_req_mode         (mode),
    .i_req_ibytes_len   (ilen),
    .i_req_obytes_len   (olen),
    .i_req_ibytes       (ibytes),
    .i_req_ibytes_valid (ivalid),
    .o_req_ibytes_ready (req_ready),
    .o_req_grant        (grant),
    .o_req_obytes       (obytes),
    .o_req_obytes_valid (ovalid),
    .o_req_done         (done),
    .o_req_err          (err),
    .o_kc_mode          (kc_mode),
    .o_kc_ibytes_len    (kc_ilen),
    .o_kc_obytes_len    (kc_olen),
    .o_kc_ibytes        (kc_ibytes),
    .o_kc_ibytes_valid  (kc_ivalid),
    .i_kc_ibytes_ready  (kc_ready),
    .i_kc_obytes        (kc_obytes),
    .i_kc_obytes_valid  (kc_ov),
    .i_kc_obytes_done   (kc_done),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] m, input logic [15:0] il,
                         input logic [15:0] ol);
    mode[2*k +: 2]  = m;
    ilen[BI*k +: BI] = il;
    olen[BO*k +: BO] = ol;
    req[k] = 1'b1;
  endtask

  // Core signals done; checks the done pulse and the grant release after it.
  task automatic finish_txn(input int k, input bit drop);
    kc_done = 1'b1;
    tick();
    check("done_pulse", 64'(done), 64'(1) << k);
    check("grant_at_done", 64'(grant), 64'(1) << k);
    check("no_err", 64'(err), 64'd0);
    kc_done = 1'b0;
    if (drop) req[k] = 1'b0;
    tick();
    check("grant_drop", 64'(grant), 64'd0);
    check("done_clear", 64'(done), 64'd0);
    check("idle", 64'(busy), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mode = '0; ilen = '0; olen = '0; ibytes = '0; ivalid = '0;
    kc_ready = 1'b0; kc_obytes = '0; kc_ov = 1'b0; kc_done = 1'b0;
    #12;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_kc_ivalid", 64'(kc_ivalid), 64'd0);
    check("rst_kc_mode", 64'(kc_mode), 64'd0);
    check("rst_kc_ilen", 64'(kc_ilen), 64'd0);
    tick();
    rst_n = 1'b1;

    // single requester, SHA3-256, 32 input bytes, 4 output beats
    set_req(0, MODE_SHA3_256, 16'd32, 16'd0);
    tick();
    check("t2_grant", 64'(grant), 64'b0001);
    check("t2_mode", 64'(kc_mode), 64'(MODE_SHA3_256));
    check("t2_ilen", 64'(kc_ilen), 64'd32);
    check("t2_busy", 64'(busy), 64'd1);
    ibytes[63:0] = 64'h0123_4567_89ab_cdef;
    ibytes[127:64] = 64'hdead_beef_0000_1111;
    kc_ready = 1'b1;
    ivalid = 4'b0010;
    #1;
    check("t2_other_valid_ignored", 64'(kc_ivalid), 64'd0);
    check("t2_ready_granted_only", 64'(req_ready), 64'b0001);
    ivalid = 4'b0001;
    #1;
    check("t2_kc_ivalid", 64'(kc_ivalid), 64'd1);
    check("t2_kc_ibytes", kc_ibytes, 64'h0123_4567_89ab_cdef);
    ivalid = 4'b0000;
    kc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kc_ov = 1'b1;
      kc_obytes = 64'hA5A5_0000_0000_0000 + 64'(i);
      tick();
      check("t2_ovalid", 64'(ovalid), 64'b0001);
      check("t2_obytes", obytes, 64'hA5A5_0000_0000_0000 + 64'(i));
    end
    kc_ov = 1'b0;
    #1;
    check("t2_ovalid_off", 64'(ovalid), 64'd0);
    finish_txn(0, 1'b1);

    // all four at once after reset: 0,1,2,3 with 2 dead cycles between
    pulse_reset();
    for (int k = 0; k < 4; k++) set_req(k, MODE_SHAKE256, 16'(8 * k + 8), 16'd64);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t3_grant_order", 64'(grant), 64'(1) << k);
      check("t3_ilen", 64'(kc_ilen), 64'(8 * k + 8));
      finish_txn(k, 1'b1);
      if (k < 3) tick();
    end

    // req1 held continuously, req2 pulses: 1,2,1
    set_req(1, MODE_SHA3_512, 16'd10, 16'd0);
    set_req(2, MODE_SHA3_256, 16'd20, 16'd0);
    tick();
    check("t4_first", 64'(grant), 64'b0010);
    finish_txn(1, 1'b0);
    tick();
    check("t4_second", 64'(grant), 64'b0100);
    check("t4_mode2", 64'(kc_mode), 64'(MODE_SHA3_256));
    finish_txn(2, 1'b1);
    tick();
    check("t4_third", 64'(grant), 64'b0010);
    check("t4_mode1", 64'(kc_mode), 64'(MODE_SHA3_512));
    finish_txn(1, 1'b1);

    // zero-length request on requester 2
    set_req(2, MODE_SHA3_256, 16'd0, 16'd0);
    ivalid = 4'b0100;
    tick();
    check("t5_grant", 64'(grant), 64'b0100);
    check("t5_kc_ivalid_err", 64'(kc_ivalid), 64'd0);
    check("t5_no_done_yet", 64'(done), 64'd0);
    tick();
    check("t5_done", 64'(done), 64'b0100);
    check("t5_err", 64'(err), 64'b0100);
    check("t5_grant_hold", 64'(grant), 64'b0100);
    check("t5_kc_ivalid_done", 64'(kc_ivalid), 64'd0);
    req[2] = 1'b0;
    ivalid = '0;
    tick();
    check("t5_grant_drop", 64'(grant), 64'd0);
    check("t5_err_clear", 64'(err), 64'd0);

    // SHAKE128, 504 output bytes, inputs change mid-stream
    set_req(0, MODE_SHAKE128, 16'd34, 16'd504);
    tick();
    check("t6_grant", 64'(grant), 64'b0001);
    mode[1:0] = MODE_SHA3_512;
    ilen[15:0] = 16'd5;
    olen[15:0] = 16'd7;
    #1;
    check("t6_mode_latched", 64'(kc_mode), 64'(MODE_SHAKE128));
    check("t6_ilen_latched", 64'(kc_ilen), 64'd34);
    check("t6_olen_latched", 64'(kc_olen), 64'd504);
    begin
      int beats;
      beats = 0;
      for (int i = 0; i < 63; i++) begin
        kc_ov = 1'b1;
        kc_obytes = {32'hC0DE_0000, 32'(i)};
        #1;
        if (ovalid == 4'b0001 && obytes == {32'hC0DE_0000, 32'(i)}) beats++;
        tick();
      end
      kc_ov = 1'b0;
      check("t6_beats_routed", 64'(beats), 64'd63);
    end
    check("t6_olen_end", 64'(kc_olen), 64'd504);
    finish_txn(0, 1'b1);

    // asynchronous reset while busy
    set_req(3, MODE_SHA3_256, 16'd8, 16'd0);
    tick();
    check("t7_grant", 64'(grant), 64'b1000);
    tick();
    check("t7_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_grant", 64'(grant), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_ilen", 64'(kc_ilen), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_regrant", 64'(grant), 64'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
